branch_comp: RTL and testbench
==============================

Name: branch_comp

Overview:
- Combinational branch comparator for the RV32I execute stage.
- Compares rs1 (in_A) against rs2 (in_B) and produces the equal and less-than flags that drive BEQ/BNE/BLT/BGE/BLTU/BGEU decisions.
- A clocked side path holds the last result for pipeline observability.
- Clock and reset affect only that side path, never the comparison flags.

Parameters:
- WIDTH, 32, operand width in bits (must be at least 2).

Ports:
- clk  input  1  system clock; clocks the observability registers only.
- reset  input  1  asynchronous, active-low reset.
- in_A  input  WIDTH  operand A (rs1 value).
- in_B  input  WIDTH  operand B (rs2 value).
- BrUn  input  2  compare mode. Bit0: 0 = unsigned compare, 1 = signed (two's complement) compare. Bit1 reserved; ignored by RTL.
- BrEq  output  1  1 when in_A == in_B.
- BrLT  output  1  1 when in_A < in_B under the mode selected by BrUn[0].
- BrEq_q  output  1  BrEq registered on rising clk.
- BrLT_q  output  1  BrLT registered on rising clk.

Behaviour:
- One clock (clk); reset is asynchronous, active-low.
- BrEq and BrLT are purely combinational from in_A, in_B and BrUn, with zero-cycle latency.
  - Outputs must be settled well within half a clock period of any input change.
  - They are unaffected by reset or clk.
- BrEq = (in_A == in_B) bitwise, independent of BrUn.
- BrLT, BrUn[0]=0: unsigned magnitude compare.
- BrLT, BrUn[0]=1: signed two's-complement compare.
  - Implement as a WIDTH+1-bit subtraction in_A - in_B with mode-dependent extension (zero-extend for unsigned, sign-extend for signed); BrLT = MSB of the difference.
- BrEq=1 forces BrLT=0 in both modes.
- BrUn[1] has no effect. Any X/Z on BrUn[1] must not propagate to the outputs.
- BrEq_q and BrLT_q:
  - Reset value 0 (async assert when reset=0).
  - After reset release, capture BrEq/BrLT on every rising clk edge.
- Boundary cases (WIDTH=32):
  - 0x80000000 vs 0x7FFFFFFF: unsigned LT=0; signed LT=1.
  - 0xFFFFFFFF vs 0x00000000: unsigned LT=0; signed LT=1.
  - 0 vs 0 gives BrEq=1, BrLT=0 in both modes.
- Reset mid-operation: only the _q registers clear; the combinational flags keep tracking the inputs.

Optional Feature:
- Macro: BRANCH_COMP_STATS_EN.
- Defined: adds outputs eq_cnt[15:0] and lt_cnt[15:0].
  - On each rising clk they increment by 1 when BrEq (respectively BrLT) is 1.
  - They wrap at 0xFFFF back to 0.
  - Cleared to 0 by reset.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Shared package riscv_pkg: constant XLEN=32; typedef br_mode_t (2-bit enum: BR_UNSIGNED=2'b00, BR_SIGNED=2'b01).
- One natural sub-module: branch_cmp_core, the combinational subtract/compare datapath producing eq and lt.
- branch_comp wraps branch_cmp_core with the result registers and the optional counters.

Test Plan:
- A=0x00000005, B=0x00000005, BrUn=0 then BrUn=1 -> BrEq=1, BrLT=0 in both modes.
- A=0x00000005, B=0x80000005, BrUn=0 -> BrEq=0, BrLT=1; same operands with BrUn=1 -> BrEq=0, BrLT=0.
- A=0x80000005, B=0x00000005, BrUn=0 -> BrEq=0, BrLT=0; same operands with BrUn=1 -> BrEq=0, BrLT=1.
- A=0xFFFFFFFF, B=0x00000000: BrUn=0 -> BrLT=0; BrUn=1 -> BrLT=1. Repeat with BrUn=2'b10/2'b11 -> identical to bit1=0.
- Drive reset=0 mid-run with nonzero flags -> BrEq_q=BrLT_q=0 immediately while BrEq/BrLT still track inputs; release reset -> _q equal the previous-cycle flags after the next posedge.
- With BRANCH_COMP_STATS_EN: hold A==B for 3 cycles -> eq_cnt=3, lt_cnt=0; preload to 0xFFFF -> wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the branch compare-mode encoding.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BR_UNSIGNED = 2'b00,
        BR_SIGNED   = 2'b01
    } br_mode_t;

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational equal / less-than datapath; zero-cycle latency, no state.
module branch_cmp_core
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sgn,
    output logic             eq,
    output logic             lt
);

    logic [WIDTH:0] diff;

    // One extra bit turns both compare modes into a single subtract whose MSB is the sign.
    always_comb begin
        diff = {sgn & a[WIDTH-1], a} - {sgn & b[WIDTH-1], b};
        eq   = (a == b);
        lt   = diff[WIDTH] & ~eq;
    end

endmodule

// File: rtl/branch_comp.sv
// RV32I branch comparator: combinational BrEq/BrLT plus registered copies for observation.
// BRANCH_COMP_STATS_EN adds wrapping 16-bit eq/lt hit counters.
module branch_comp
    import riscv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [1:0]       BrUn,
    output logic             BrEq,
    output logic             BrLT,
    output logic             BrEq_q,
    output logic             BrLT_q
`ifdef BRANCH_COMP_STATS_EN
    ,
    output logic [15:0]      eq_cnt,
    output logic [15:0]      lt_cnt
`endif
);

    br_mode_t mode;
    logic     br_mode_unused;

    // Only bit0 reaches the datapath, so an undriven bit1 cannot leak into the flags.
    assign mode           = br_mode_t'({1'b0, BrUn[0]});
    assign br_mode_unused = BrUn[1];

    branch_cmp_core #(.WIDTH(WIDTH)) u_core (
        .a   (in_A),
        .b   (in_B),
        .sgn (mode == BR_SIGNED),
        .eq  (BrEq),
        .lt  (BrLT)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            BrEq_q <= 1'b0;
            BrLT_q <= 1'b0;
        end else begin
            BrEq_q <= BrEq;
            BrLT_q <= BrLT;
        end
    end

`ifdef BRANCH_COMP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eq_cnt <= 16'd0;
            lt_cnt <= 16'd0;
        end else begin
            if (BrEq) eq_cnt <= eq_cnt + 16'd1;
            if (BrLT) lt_cnt <= lt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_comp.sv
// Scoreboard bench for branch_comp: directed vectors with hand-computed flags.
module tb_branch_comp;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_A, in_B;
    logic [1:0]  BrUn;
    logic        BrEq, BrLT, BrEq_q, BrLT_q;
`ifdef BRANCH_COMP_STATS_EN
    logic [15:0] eq_cnt, lt_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   id;
        logic eq;
        logic lt;
        logic eq_q;
        logic lt_q;
    } exp_t;

    exp_t sb[$];
    logic prev_eq, prev_lt;
    int   vec_id = 0;

    branch_comp #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_A   (in_A),
        .in_B   (in_B),
        .BrUn   (BrUn),
        .BrEq   (BrEq),
        .BrLT   (BrLT),
        .BrEq_q (BrEq_q),
        .BrLT_q (BrLT_q)
`ifdef BRANCH_COMP_STATS_EN
        ,
        .eq_cnt (eq_cnt),
        .lt_cnt (lt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, id, act, exp);
        end
    endtask

    // Drive one vector for a full cycle; the registered flags must show the previous cycle's result.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         input logic eeq, input logic elt);
        exp_t e;
        @(posedge clk);
        #1;
        in_A = a;
        in_B = b;
        BrUn = m;
        e.id   = vec_id;
        e.eq   = eeq;
        e.lt   = elt;
        e.eq_q = prev_eq;
        e.lt_q = prev_lt;
        sb.push_back(e);
        vec_id++;
        prev_eq = eeq;
        prev_lt = elt;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("BrEq",   e.id, {31'd0, BrEq},   {31'd0, e.eq});
            chk("BrLT",   e.id, {31'd0, BrLT},   {31'd0, e.lt});
            chk("BrEq_q", e.id, {31'd0, BrEq_q}, {31'd0, e.eq_q});
            chk("BrLT_q", e.id, {31'd0, BrLT_q}, {31'd0, e.lt_q});
        end
    end

    initial begin
        reset = 1'b0;
        in_A  = 32'd0;
        in_B  = 32'd0;
        BrUn  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_BrEq_q", -1, {31'd0, BrEq_q}, 32'd0);
        chk("rst_BrLT_q", -1, {31'd0, BrLT_q}, 32'd0);
        chk("rst_BrEq_comb", -1, {31'd0, BrEq}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        // Idle inputs are 0 vs 0, so the first capture after release is eq=1, lt=0.
        prev_eq = 1'b1;
        prev_lt = 1'b0;

        apply(32'h0000_0005, 32'h0000_0005, 2'b00, 1'b1, 1'b0);
        apply(32'h0000_0005, 32'h0000_0005, 2'b01, 1'b1, 1'b0);
        apply(32'h0000_0005, 32'h8000_0005, 2'b00, 1'b0, 1'b1);
        apply(32'h0000_0005, 32'h8000_0005, 2'b01, 1'b0, 1'b0);
        apply(32'h8000_0005, 32'h0000_0005, 2'b00, 1'b0, 1'b0);
        apply(32'h8000_0005, 32'h0000_0005, 2'b01, 1'b0, 1'b1);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 2'b00, 1'b0, 1'b0);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 2'b01, 1'b0, 1'b1);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 1'b0, 1'b0);
        apply(32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 1'b0, 1'b1);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 1'b0, 1'b0);
        apply(32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 1'b0, 1'b1);
        apply(32'h0000_0000, 32'h0000_0000, 2'b00, 1'b1, 1'b0);
        apply(32'h0000_0000, 32'h0000_0000, 2'b11, 1'b1, 1'b0);
        apply(32'h0000_0003, 32'h0000_0007, 2'b00, 1'b0, 1'b1);
        apply(32'h0000_0007, 32'h0000_0003, 2'b01, 1'b0, 1'b0);
        apply(32'hFFFF_FFFE, 32'hFFFF_FFFF, 2'b01, 1'b0, 1'b1);

        // Reset mid-run: lt=1 is live; only the registered copies should drop.
        apply(32'h0000_0003, 32'h0000_0007, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_BrEq_q", -2, {31'd0, BrEq_q}, 32'd0);
        chk("midrst_BrLT_q", -2, {31'd0, BrLT_q}, 32'd0);
        chk("midrst_BrLT",   -2, {31'd0, BrLT},   32'd1);
        chk("midrst_BrEq",   -2, {31'd0, BrEq},   32'd0);
        in_A = 32'h0000_0009;
        in_B = 32'h0000_0009;
        #1;
        chk("midrst_track_BrEq", -2, {31'd0, BrEq}, 32'd1);
        chk("midrst_track_BrLT", -2, {31'd0, BrLT}, 32'd0);
        reset = 1'b1;
        prev_eq = 1'b1;
        prev_lt = 1'b0;
        apply(32'h0000_000A, 32'h0000_0003, 2'b01, 1'b0, 1'b0);
        apply(32'h8000_0000, 32'h0000_0001, 2'b01, 1'b0, 1'b1);
        apply(32'h0000_0001, 32'h0000_0002, 2'b10, 1'b0, 1'b1);

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

`ifdef BRANCH_COMP_STATS_EN
        @(negedge clk);
        reset = 1'b0;
        in_A  = 32'h0000_0005;
        in_B  = 32'h0000_0005;
        BrUn  = 2'b00;
        #1;
        chk("stats_rst_eq_cnt", -3, {16'd0, eq_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stats_eq_cnt_3", -3, {16'd0, eq_cnt}, 32'd3);
        chk("stats_lt_cnt_0", -3, {16'd0, lt_cnt}, 32'd0);
        repeat (65532) @(posedge clk);
        #1;
        chk("stats_eq_cnt_ffff", -3, {16'd0, eq_cnt}, 32'hFFFF);
        @(posedge clk);
        #1;
        chk("stats_eq_cnt_wrap", -3, {16'd0, eq_cnt}, 32'd0);
        chk("stats_lt_cnt_wrap", -3, {16'd0, lt_cnt}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
